// File: rtl/controlador_somador_dr_if.sv
// Requester and dual-rail adder bus of controlador_somador_dr.
// master: requesters plus the asynchronous adder side; slave: the controller.
interface controlador_somador_dr_if;
    logic       req0;
    logic       req1;
    logic [3:0] a0;
    logic [3:0] a1;
    logic [3:0] b0;
    logic [3:0] b1;
    logic       cin0;
    logic       cin1;
    logic       ack0;
    logic       ack1;
    logic [3:0] res_s;
    logic       res_cout;
    logic       res_err;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic [1:0] add_cin;
    logic [7:0] add_s;
    logic [1:0] add_cout;
    logic       busy;
    logic       err_sticky;

    modport master (
        output req0, req1, a0, a1, b0, b1, cin0, cin1, add_s, add_cout,
        input  ack0, ack1, res_s, res_cout, res_err, add_a, add_b, add_cin,
               busy, err_sticky
    );

    modport slave (
        input  req0, req1, a0, a1, b0, b1, cin0, cin1, add_s, add_cout,
        output ack0, ack1, res_s, res_cout, res_err, add_a, add_b, add_cin,
               busy, err_sticky
    );
endinterface

// File: rtl/controlador_somador_dr.sv
// Round-robin sequencer for one shared 4-bit dual-rail adder: DATA, completion,
// NULL spacer, all-null, with timeout and illegal-code detection.
module controlador_somador_dr #(
    parameter int SYNC_STAGES = 2,   // >= 2
    parameter int TIMEOUT     = 64   // 4 .. 255
) (
    input  logic                    clk,
    input  logic                    rst,
    controlador_somador_dr_if.slave bus
);

    typedef enum logic [2:0] {
        S_WNULL,
        S_IDLE,
        S_DATA,
        S_NULL,
        S_FAULT
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    function automatic logic [7:0] dr_enc4(input logic [3:0] v);
        logic [7:0] r;
        for (int i = 0; i < 4; i++) begin
            r[2*i +: 2] = v[i] ? 2'b01 : 2'b10;
        end
        return r;
    endfunction

    function automatic logic [1:0] dr_enc1(input logic v);
        return v ? 2'b01 : 2'b10;
    endfunction

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       gnt_q, gnt_d;
    logic       last_q, last_d;
    logic [7:0] add_a_q, add_a_d;
    logic [7:0] add_b_q, add_b_d;
    logic [1:0] add_cin_q, add_cin_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic [3:0] res_s_q, res_s_d;
    logic       res_cout_q, res_cout_d;
    logic       res_err_q, res_err_d;
    logic       busy_q, busy_d;
    logic       err_q, err_d;

    logic [9:0] sync_q [SYNC_STAGES];
    logic [9:0] sync_d [SYNC_STAGES];

    logic [9:0] rails;
    logic       all_null;
    logic       all_valid;
    logic       any_illegal;
    logic       timeout;
    logic       pick;

    always_comb begin
        sync_d[0] = {bus.add_cout, bus.add_s};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // NOTE: the chain resets to all-ones, not zero, so WNULL cannot see a
    // fake all-null before the adder's real rails have propagated through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
        end
    end

    assign rails = sync_q[SYNC_STAGES-1];

    always_comb begin
        all_null    = (rails == '0);
        all_valid   = 1'b1;
        any_illegal = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (rails[2*i+1] & rails[2*i])     any_illegal = 1'b1;
            if (!(rails[2*i+1] ^ rails[2*i]))  all_valid   = 1'b0;
        end
    end

    assign timeout = (cnt_q == CNT_LAST);
    assign pick    = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        add_a_d    = add_a_q;
        add_b_d    = add_b_q;
        add_cin_d  = add_cin_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        res_s_d    = res_s_q;
        res_cout_d = res_cout_q;
        res_err_d  = res_err_q;
        err_d      = err_q;

        unique case (state_q)
            S_WNULL: begin
                add_a_d   = '0;
                add_b_d   = '0;
                add_cin_d = '0;
                if (all_null) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    gnt_d     = pick;
                    add_a_d   = dr_enc4(pick ? bus.a1 : bus.a0);
                    add_b_d   = dr_enc4(pick ? bus.b1 : bus.b0);
                    add_cin_d = dr_enc1(pick ? bus.cin1 : bus.cin0);
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (any_illegal || all_valid || timeout) begin
                    ack0_d    = ~gnt_q;
                    ack1_d    = gnt_q;
                    add_a_d   = '0;
                    add_b_d   = '0;
                    add_cin_d = '0;
                    state_d   = S_NULL;
                    if (all_valid) begin
                        // The true rail of each pair is the even bit.
                        res_s_d    = {rails[6], rails[4], rails[2], rails[0]};
                        res_cout_d = rails[8];
                        res_err_d  = 1'b0;
                    end else begin
                        res_s_d    = '0;
                        res_cout_d = 1'b0;
                        res_err_d  = 1'b1;
                        err_d      = 1'b1;
                    end
                end
            end
            S_NULL: begin
                add_a_d   = '0;
                add_b_d   = '0;
                add_cin_d = '0;
                if (all_null) begin
                    last_d  = gnt_q;
                    state_d = S_IDLE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_FAULT;
                end
            end
            S_FAULT: begin
                add_a_d   = '0;
                add_b_d   = '0;
                add_cin_d = '0;
            end
            default: state_d = S_WNULL;
        endcase

        if (state_d != state_q)   cnt_d = '0;
        else if (cnt_q != 8'hFF)  cnt_d = cnt_q + 8'd1;
        else                      cnt_d = cnt_q;

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_WNULL;
            cnt_q      <= '0;
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            add_a_q    <= '0;
            add_b_q    <= '0;
            add_cin_q  <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            res_s_q    <= '0;
            res_cout_q <= 1'b0;
            res_err_q  <= 1'b0;
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            add_a_q    <= add_a_d;
            add_b_q    <= add_b_d;
            add_cin_q  <= add_cin_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            res_s_q    <= res_s_d;
            res_cout_q <= res_cout_d;
            res_err_q  <= res_err_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign bus.add_a      = add_a_q;
    assign bus.add_b      = add_b_q;
    assign bus.add_cin    = add_cin_q;
    assign bus.ack0       = ack0_q;
    assign bus.ack1       = ack1_q;
    assign bus.res_s      = res_s_q;
    assign bus.res_cout   = res_cout_q;
    assign bus.res_err    = res_err_q;
    assign bus.busy       = busy_q;
    assign bus.err_sticky = err_q;

endmodule

// File: tb/tb_controlador_somador_dr.sv
// Self-checking bench: behavioural dual-rail adder with random per-rail delay,
// random operand/requester stimulus, reference sums from plain arithmetic.
module tb_controlador_somador_dr;

    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 64;

    typedef enum {M_NORMAL, M_NEVER, M_ILLEGAL, M_STUCK} mode_e;

    logic  clk = 1'b0;
    logic  rst;
    mode_e mode = M_NORMAL;

    logic [9:0] rails = '0;
    int         dly [10] = '{default: 0};

    int errors = 0;
    int checks = 0;

    logic [7:0] cap_a;
    logic [7:0] cap_b;
    logic [1:0] cap_cin;

    controlador_somador_dr_if bus ();

    controlador_somador_dr #(
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] dr4(input logic [3:0] v);
        logic [7:0] r;
        for (int i = 0; i < 4; i++) r[2*i +: 2] = v[i] ? 2'b01 : 2'b10;
        return r;
    endfunction

    function automatic logic [9:0] dr5(input logic [4:0] v);
        logic [9:0] r;
        for (int i = 0; i < 5; i++) r[2*i +: 2] = v[i] ? 2'b01 : 2'b10;
        return r;
    endfunction

    // Adder model: outputs switch only once inputs are fully DATA or fully
    // NULL; each rail moves after its own random 1..10 cycle delay.
    task automatic model_step();
        logic [17:0] x;
        logic [9:0]  tgt;
        logic [3:0]  av, bv;
        logic        in_valid, in_null;
        logic [4:0]  s;
        x        = {bus.add_cin, bus.add_b, bus.add_a};
        in_null  = (x == '0);
        in_valid = 1'b1;
        for (int p = 0; p < 9; p++) if (x[2*p] == x[2*p+1]) in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            av[i] = bus.add_a[2*i];
            bv[i] = bus.add_b[2*i];
        end
        s   = 5'(av) + 5'(bv) + 5'(bus.add_cin[0]);
        tgt = rails;
        case (mode)
            M_NORMAL:  if (in_valid) tgt = dr5(s); else if (in_null) tgt = '0;
            M_NEVER:   tgt = '0;
            M_ILLEGAL: if (in_valid) tgt = 10'b00_0000_0011; else if (in_null) tgt = '0;
            M_STUCK:   if (in_valid) tgt = dr5(s);
            default:   tgt = rails;
        endcase
        for (int r = 0; r < 10; r++) begin
            if (rails[r] != tgt[r]) begin
                if (dly[r] == 0) dly[r] = $urandom_range(1, 10);
                else begin
                    dly[r]--;
                    if (dly[r] == 0) rails[r] = tgt[r];
                end
            end else begin
                dly[r] = 0;
            end
        end
        bus.add_s    = rails[7:0];
        bus.add_cout = rails[9:8];
    endtask

    always @(negedge clk) model_step();

    task automatic drive_ops(input int r, input logic [3:0] a, input logic [3:0] b, input logic c);
        if (r == 0) begin bus.a0 = a; bus.b0 = b; bus.cin0 = c; end
        else        begin bus.a1 = a; bus.b1 = b; bus.cin1 = c; end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy && n < 300) begin @(negedge clk); n++; end
        check(tag, n < 300, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_idle("reset_to_idle");
    endtask

    task automatic do_txn(input int r, input logic [3:0] a, input logic [3:0] b, input logic c,
                          input bit exp_err, input bit idle_after, output int lat);
        int         n;
        logic [4:0] s;
        s = 5'(a) + 5'(b) + 5'(c);
        drive_ops(r, a, b, c);
        if (r == 0) bus.req0 = 1'b1; else bus.req1 = 1'b1;
        n = 0;
        while (bus.add_a == 8'h00 && n < 100) begin @(negedge clk); n++; end
        check("data_entry", n < 100, 1);
        check("busy_data", bus.busy, 1);
        cap_a   = bus.add_a;
        cap_b   = bus.add_b;
        cap_cin = bus.add_cin;
        check("enc_ops", {cap_cin, cap_b, cap_a}, {(c ? 2'b01 : 2'b10), dr4(b), dr4(a)});
        lat = 0;
        while (!(bus.ack0 || bus.ack1) && lat < 300) begin @(negedge clk); lat++; end
        check("ack_seen", lat < 300, 1);
        check("ack_who", {bus.ack1, bus.ack0}, (r == 1) ? 2'b10 : 2'b01);
        check("res_err", bus.res_err, exp_err);
        if (!exp_err) begin
            check("res_sum", {bus.res_cout, bus.res_s}, s);
            check("lat_min", lat >= SYNC_STAGES + 1, 1);
        end
        check("null_at_ack", {bus.add_cin, bus.add_b, bus.add_a}, 0);
        if (r == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
        @(negedge clk);
        check("ack_pulse", {bus.ack1, bus.ack0}, 0);
        if (!exp_err) check("res_hold", {bus.res_cout, bus.res_s}, s);
        if (idle_after) wait_idle("txn_idle");
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n, lat, ex;
        bit         saw, seen;
        logic [3:0] ra [2];
        logic [3:0] rb [2];
        logic       rc [2];
        logic [4:0] s;
        logic [8:0] v;

        rst = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        drive_ops(0, 4'h0, 4'h0, 1'b0);
        drive_ops(1, 4'h0, 4'h0, 1'b0);
        bus.add_s = '0; bus.add_cout = '0;
        repeat (2) @(negedge clk);
        check("rst_add", {bus.add_cin, bus.add_b, bus.add_a}, 0);
        check("rst_ack", {bus.ack1, bus.ack0}, 0);
        check("rst_res", {bus.res_err, bus.res_cout, bus.res_s}, 0);
        check("rst_sticky", bus.err_sticky, 0);
        check("rst_busy", bus.busy, 1);
        rst = 1'b0;
        wait_idle("first_idle");

        // Single transaction with known encoding and result.
        do_txn(0, 4'd5, 4'd3, 1'b0, 0, 1, lat);
        check("t1_add_a", cap_a, 8'h99);
        check("t1_add_b", cap_b, 8'hA5);
        check("t1_add_cin", cap_cin, 2'b10);
        check("t1_res", {bus.res_err, bus.res_cout, bus.res_s}, 6'h08);

        do_txn(1, 4'hF, 4'h1, 1'b1, 0, 1, lat);
        check("t2_res", {bus.res_cout, bus.res_s}, 5'h11);

        // Full operand sweep with random requester.
        for (int i = 0; i < 512; i++) begin
            v = 9'(i);
            do_txn(int'($urandom_range(0, 1)), v[3:0], v[7:4], v[8], 0, 1, lat);
        end

        // Both requesters held after reset: strict alternation, NULL between.
        do_reset();
        for (int q = 0; q < 2; q++) begin
            ra[q] = 4'($urandom); rb[q] = 4'($urandom); rc[q] = 1'($urandom);
            drive_ops(q, ra[q], rb[q], rc[q]);
        end
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            saw = (k == 0);
            while (bus.add_a == 8'h00 && n < 200) begin
                if (rails == '0) saw = 1'b1;
                @(negedge clk); n++;
            end
            check("rr_null_gap", saw, 1);
            n = 0;
            while (!(bus.ack0 || bus.ack1) && n < 300) begin @(negedge clk); n++; end
            ex = k % 2;
            check("rr_grant", {bus.ack1, bus.ack0}, (ex == 1) ? 2'b10 : 2'b01);
            s = 5'(ra[ex]) + 5'(rb[ex]) + 5'(rc[ex]);
            check("rr_sum", {bus.res_err, bus.res_cout, bus.res_s}, {1'b0, s});
            check("rr_null_at_ack", {bus.add_cin, bus.add_b, bus.add_a}, 0);
            ra[ex] = 4'($urandom); rb[ex] = 4'($urandom); rc[ex] = 1'($urandom);
            drive_ops(ex, ra[ex], rb[ex], rc[ex]);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        wait_idle("rr_idle");

        // Adder never completes: timeout ack exactly TIMEOUT cycles after DATA entry.
        mode = M_NEVER;
        do_txn(0, 4'($urandom), 4'($urandom), 1'b1, 1, 1, lat);
        check("to_latency", lat, TIMEOUT);
        check("to_res_zero", {bus.res_cout, bus.res_s}, 0);
        check("to_sticky", bus.err_sticky, 1);
        mode = M_NORMAL;

        // Illegal code on the sum.
        do_reset();
        check("sticky_cleared", bus.err_sticky, 0);
        mode = M_ILLEGAL;
        do_txn(1, 4'($urandom), 4'($urandom), 1'b0, 1, 1, lat);
        check("ill_sticky", bus.err_sticky, 1);

        // Adder stuck non-null in NULL: FAULT, no further grants until reset.
        mode = M_STUCK;
        do_reset();
        check("sticky_cleared2", bus.err_sticky, 0);
        do_txn(0, 4'($urandom), 4'($urandom), 1'b1, 0, 0, lat);
        repeat (TIMEOUT + 40) @(negedge clk);
        check("fault_busy", bus.busy, 1);
        check("fault_sticky", bus.err_sticky, 1);
        mode = M_NORMAL;
        drive_ops(1, 4'h7, 4'h2, 1'b0);
        bus.req1 = 1'b1;
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1 || bus.add_a != 8'h00) seen = 1'b1;
        end
        check("fault_quiet", seen, 0);
        bus.req1 = 1'b0;
        do_reset();

        // Reset while the adder still shows DATA.
        drive_ops(0, 4'hA, 4'h6, 1'b1);
        bus.req0 = 1'b1;
        n = 0;
        while (rails == '0 && n < 100) begin @(negedge clk); n++; end
        check("mid_data_reached", n < 100, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_null", {bus.add_cin, bus.add_b, bus.add_a}, 0);
        check("rst_async_busy", bus.busy, 1);
        bus.req0 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        seen = 1'b0;
        while (bus.busy && n < 300) begin
            if (bus.ack0 || bus.ack1) seen = 1'b1;
            @(negedge clk); n++;
        end
        check("rst_recover_idle", n < 300, 1);
        check("rst_no_ack", seen, 0);
        check("rst_rails_null", rails, 0);
        do_txn(0, 4'hC, 4'h9, 1'b1, 0, 1, lat);
        do_txn(1, 4'($urandom), 4'($urandom), 1'($urandom), 0, 1, lat);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
